// File: rtl/scale_cntr_monitor_pkg.sv
// ---------------------------------------------------------------------------
// scale_cntr_mon_pkg
//   Shared definitions for the PLL scale-down counter output monitor:
//   monitor FSM state encoding, default parameter values and a helper that
//   yields the all-ones (saturation) value for a given counter width.
//   No ports (package).
// ---------------------------------------------------------------------------
package scale_cntr_mon_pkg;

    localparam int unsigned MON_CW_DEF         = 16;
    localparam int unsigned MON_TIMEOUT_DEF    = 4096;
    localparam int unsigned MON_LOCK_COUNT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FIRST = 3'd1,
        ST_MEAS_HIGH  = 3'd2,
        ST_MEAS_LOW   = 3'd3,
        ST_STUCK      = 3'd4
    } mon_state_e;

    // Largest value representable in w bits (w limited to 32).
    function automatic logic [31:0] sat_max(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/scale_cntr_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   CW-bit up counter that sticks at 2^CW-1 instead of wrapping.
//   Ports:
//     clk_i      - clock
//     rst_ni     - asynchronous active-low reset (count -> 0)
//     clr_i      - synchronous clear (highest priority)
//     load1_i    - synchronous load of 1 (a new measurement starts)
//     inc_i      - increment by one, saturating
//     limit_i    - compare value for at_limit_o
//     cnt_o      - current count
//     at_limit_o - count equals limit_i
// ---------------------------------------------------------------------------
module sat_counter
    import scale_cntr_mon_pkg::*;
#(
    parameter int unsigned CW = MON_CW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          load1_i,
    input  logic          inc_i,
    input  logic [CW-1:0] limit_i,
    output logic [CW-1:0] cnt_o,
    output logic          at_limit_o
);

    localparam logic [31:0]   MAX32   = sat_max(CW);
    localparam logic [CW-1:0] CNT_MAX = MAX32[CW-1:0];

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = CW'(1);
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/scale_cntr_monitor.sv
// ---------------------------------------------------------------------------
// scale_cntr_monitor
//   Watches a divided clock (cin) produced by a PLL scale-down counter and
//   measures, in clk cycles, the delay from arming to the first rising edge
//   and the high/low phase lengths of every complete period. Each period is
//   compared against exp_high/exp_low; matching periods build up lock, a
//   phase (or initial wait) longer than TIMEOUT flags the output as stuck.
//   Ports:
//     clk          - sampling clock (the counter's source clock)
//     reset_n      - asynchronous active-low reset
//     enable       - arm/run; low returns the monitor to idle
//     cin          - observed divided clock, synchronous to clk
//     exp_high     - expected high-phase length
//     exp_low      - expected low-phase length
//     meas_initial - arming-to-first-rise delay, valid with init_valid
//     init_valid   - one-cycle pulse when meas_initial updates
//     meas_high    - high-phase length of the last complete period
//     meas_low     - low-phase length of the last complete period
//     meas_valid   - one-cycle pulse when meas_high/meas_low update
//     mismatch     - pulses with meas_valid if the period differs from expected
//     locked       - LOCK_COUNT consecutive matching periods seen
//     stuck        - no edge of cin within TIMEOUT cycles
//     stuck_level  - sampled level of cin while stuck
// ---------------------------------------------------------------------------
module scale_cntr_monitor
    import scale_cntr_mon_pkg::*;
#(
    parameter int unsigned CW         = MON_CW_DEF,
    parameter int unsigned TIMEOUT    = MON_TIMEOUT_DEF,
    parameter int unsigned LOCK_COUNT = MON_LOCK_COUNT_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          cin,
    input  logic [CW-1:0] exp_high,
    input  logic [CW-1:0] exp_low,
    output logic [CW-1:0] meas_initial,
    output logic          init_valid,
    output logic [CW-1:0] meas_high,
    output logic [CW-1:0] meas_low,
    output logic          meas_valid,
    output logic          mismatch,
    output logic          locked,
    output logic          stuck,
    output logic          stuck_level
);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam int unsigned   LCW       = $clog2(LOCK_COUNT + 1);
    localparam logic [LCW-1:0] LOCK_C   = LCW'(LOCK_COUNT);

    // cin_s_q is cin registered; cin_s_dly_q is that sample one cycle older.
    logic cin_s_q;
    logic cin_s_dly_q;
    logic rise;
    logic fall;

    mon_state_e state_q, state_d;
    logic       stuck_q, stuck_d;
    logic       stuck_lvl_q, stuck_lvl_d;

    logic init_clr, init_ld, init_inc;
    logic hi_clr, hi_ld, hi_inc;
    logic lo_clr, lo_ld, lo_inc;
    logic cap_init, cap_per, go_stuck;

    logic [CW-1:0] init_cnt, hi_cnt, lo_cnt;
    logic          init_at_lim, hi_at_lim, lo_at_lim;
    logic          per_mism;

    // Capture stage: values latched when the period completes, published
    // one cycle later together with their valid pulse.
    logic          init_pend_q;
    logic [CW-1:0] init_hold_q;
    logic          per_pend_q;
    logic [CW-1:0] hi_hold_q;
    logic [CW-1:0] lo_hold_q;
    logic          mism_pend_q;

    logic [CW-1:0]  meas_initial_q;
    logic           init_valid_q;
    logic [CW-1:0]  meas_high_q;
    logic [CW-1:0]  meas_low_q;
    logic           meas_valid_q;
    logic           mismatch_q;
    logic [LCW-1:0] lock_cnt_q;
    logic [LCW-1:0] lock_inc;
    logic           locked_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cin_s_q     <= 1'b0;
            cin_s_dly_q <= 1'b0;
        end else begin
            cin_s_q     <= cin;
            cin_s_dly_q <= cin_s_q;
        end
    end

    assign rise = cin_s_q & ~cin_s_dly_q;
    assign fall = ~cin_s_q & cin_s_dly_q;

    sat_counter #(.CW(CW)) u_init_cnt (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .clr_i      (init_clr),
        .load1_i    (init_ld),
        .inc_i      (init_inc),
        .limit_i    (TIMEOUT_C),
        .cnt_o      (init_cnt),
        .at_limit_o (init_at_lim)
    );

    sat_counter #(.CW(CW)) u_hi_cnt (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .clr_i      (hi_clr),
        .load1_i    (hi_ld),
        .inc_i      (hi_inc),
        .limit_i    (TIMEOUT_C),
        .cnt_o      (hi_cnt),
        .at_limit_o (hi_at_lim)
    );

    sat_counter #(.CW(CW)) u_lo_cnt (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .clr_i      (lo_clr),
        .load1_i    (lo_ld),
        .inc_i      (lo_inc),
        .limit_i    (TIMEOUT_C),
        .cnt_o      (lo_cnt),
        .at_limit_o (lo_at_lim)
    );

    assign per_mism = (hi_cnt != exp_high) || (lo_cnt != exp_low);
    assign lock_inc = (lock_cnt_q == LOCK_C) ? lock_cnt_q : lock_cnt_q + LCW'(1);

    // Edges are tested before the timeout limit so an edge arriving in the
    // same cycle as the limit ends the phase normally.
    always_comb begin
        state_d     = state_q;
        stuck_d     = stuck_q;
        stuck_lvl_d = stuck_lvl_q;
        init_clr    = 1'b0;
        init_ld     = 1'b0;
        init_inc    = 1'b0;
        hi_clr      = 1'b0;
        hi_ld       = 1'b0;
        hi_inc      = 1'b0;
        lo_clr      = 1'b0;
        lo_ld       = 1'b0;
        lo_inc      = 1'b0;
        cap_init    = 1'b0;
        cap_per     = 1'b0;
        go_stuck    = 1'b0;

        if (!enable) begin
            state_d     = ST_IDLE;
            stuck_d     = 1'b0;
            stuck_lvl_d = 1'b0;
            init_clr    = 1'b1;
            hi_clr      = 1'b1;
            lo_clr      = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_FIRST;
                    init_ld = 1'b1;
                    hi_clr  = 1'b1;
                    lo_clr  = 1'b1;
                end
                ST_WAIT_FIRST: begin
                    if (rise) begin
                        cap_init = 1'b1;
                        hi_ld    = 1'b1;
                        state_d  = ST_MEAS_HIGH;
                    end else if (init_at_lim) begin
                        go_stuck = 1'b1;
                    end else begin
                        init_inc = 1'b1;
                    end
                end
                ST_MEAS_HIGH: begin
                    if (fall) begin
                        lo_ld   = 1'b1;
                        state_d = ST_MEAS_LOW;
                    end else if (hi_at_lim) begin
                        go_stuck = 1'b1;
                    end else if (cin_s_q) begin
                        hi_inc = 1'b1;
                    end
                end
                ST_MEAS_LOW: begin
                    if (rise) begin
                        cap_per = 1'b1;
                        hi_ld   = 1'b1;
                        state_d = ST_MEAS_HIGH;
                    end else if (lo_at_lim) begin
                        go_stuck = 1'b1;
                    end else if (!cin_s_q) begin
                        lo_inc = 1'b1;
                    end
                end
                ST_STUCK: begin
                    if (rise) begin
                        stuck_d     = 1'b0;
                        stuck_lvl_d = 1'b0;
                        hi_ld       = 1'b1;
                        state_d     = ST_MEAS_HIGH;
                    end else if (fall) begin
                        stuck_lvl_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (go_stuck) begin
                state_d     = ST_STUCK;
                stuck_d     = 1'b1;
                stuck_lvl_d = cin_s_q;
                init_clr    = 1'b1;
                hi_clr      = 1'b1;
                lo_clr      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            stuck_q        <= 1'b0;
            stuck_lvl_q    <= 1'b0;
            init_pend_q    <= 1'b0;
            init_hold_q    <= '0;
            per_pend_q     <= 1'b0;
            hi_hold_q      <= '0;
            lo_hold_q      <= '0;
            mism_pend_q    <= 1'b0;
            meas_initial_q <= '0;
            init_valid_q   <= 1'b0;
            meas_high_q    <= '0;
            meas_low_q     <= '0;
            meas_valid_q   <= 1'b0;
            mismatch_q     <= 1'b0;
            lock_cnt_q     <= '0;
            locked_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stuck_q     <= stuck_d;
            stuck_lvl_q <= stuck_lvl_d;

            init_pend_q <= cap_init;
            per_pend_q  <= cap_per;
            if (cap_init) begin
                init_hold_q <= init_cnt;
            end
            if (cap_per) begin
                hi_hold_q   <= hi_cnt;
                lo_hold_q   <= lo_cnt;
                mism_pend_q <= per_mism;
            end

            init_valid_q <= 1'b0;
            meas_valid_q <= 1'b0;
            mismatch_q   <= 1'b0;

            // Publish stage; a pending result is dropped if enable fell.
            if (init_pend_q && enable) begin
                meas_initial_q <= init_hold_q;
                init_valid_q   <= 1'b1;
            end
            if (per_pend_q && enable) begin
                meas_high_q  <= hi_hold_q;
                meas_low_q   <= lo_hold_q;
                meas_valid_q <= 1'b1;
                mismatch_q   <= mism_pend_q;
                if (mism_pend_q) begin
                    lock_cnt_q <= '0;
                    locked_q   <= 1'b0;
                end else begin
                    lock_cnt_q <= lock_inc;
                    locked_q   <= (lock_inc == LOCK_C);
                end
            end

            if (!enable || go_stuck) begin
                lock_cnt_q <= '0;
                locked_q   <= 1'b0;
            end
        end
    end

    assign meas_initial = meas_initial_q;
    assign init_valid   = init_valid_q;
    assign meas_high    = meas_high_q;
    assign meas_low     = meas_low_q;
    assign meas_valid   = meas_valid_q;
    assign mismatch     = mismatch_q;
    assign locked       = locked_q;
    assign stuck        = stuck_q;
    assign stuck_level  = stuck_lvl_q;

endmodule

// File: tb/tb_scale_cntr_monitor.sv
// ---------------------------------------------------------------------------
// tb_scale_cntr_monitor
//   Directed bench for scale_cntr_monitor. cin is driven one sample per clk
//   cycle; outputs are read 1 ns after the rising edge. A negedge monitor
//   counts meas_valid and mismatch pulses so stretches of stimulus can be
//   checked against hand-counted totals.
// ---------------------------------------------------------------------------
module tb_scale_cntr_monitor;

    localparam int unsigned CW = 16;
    localparam int unsigned TO = 40;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          cin;
    logic [CW-1:0] exp_high;
    logic [CW-1:0] exp_low;
    logic [CW-1:0] meas_initial;
    logic          init_valid;
    logic [CW-1:0] meas_high;
    logic [CW-1:0] meas_low;
    logic          meas_valid;
    logic          mismatch;
    logic          locked;
    logic          stuck;
    logic          stuck_level;

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_mism  = 0;
    int bv;
    int bm;

    always #5 clk = ~clk;

    scale_cntr_monitor #(
        .CW         (CW),
        .TIMEOUT    (TO),
        .LOCK_COUNT (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cin          (cin),
        .exp_high     (exp_high),
        .exp_low      (exp_low),
        .meas_initial (meas_initial),
        .init_valid   (init_valid),
        .meas_high    (meas_high),
        .meas_low     (meas_low),
        .meas_valid   (meas_valid),
        .mismatch     (mismatch),
        .locked       (locked),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    always @(negedge clk) begin
        if (meas_valid) n_valid++;
        if (mismatch)   n_mism++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic c);
        cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int hi, input int lo);
        repeat (hi) tick(1'b1);
        repeat (lo) tick(1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        cin      = 1'b0;
        exp_high = 16'd3;
        exp_low  = 16'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_meas_initial", int'(meas_initial), 0);
        chk("rst_meas_high",    int'(meas_high), 0);
        chk("rst_locked",       int'(locked), 0);
        chk("rst_stuck",        int'(stuck), 0);
        reset_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("idle_valid", int'(meas_valid), 0);

        // 5 low samples after arming, then high 3 / low 2
        bv = n_valid; bm = n_mism;
        enable = 1'b1;
        repeat (5) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        chk("init_valid_early", int'(init_valid), 0);
        tick(1'b1);
        chk("init_valid",   int'(init_valid), 1);
        chk("meas_initial", int'(meas_initial), 6);
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b1);
        chk("valid_early", int'(meas_valid), 0);
        tick(1'b1);
        chk("valid_first", int'(meas_valid), 1);
        chk("meas_high_32", int'(meas_high), 3);
        chk("meas_low_32",  int'(meas_low), 2);
        chk("mism_first",   int'(mismatch), 0);
        tick(1'b0); tick(1'b0);
        repeat (2) period(3, 2);
        tick(1'b1); tick(1'b1);
        chk("locked_after3", int'(locked), 0);
        tick(1'b1);
        chk("locked_after4", int'(locked), 1);
        chk("valid_fourth",  int'(meas_valid), 1);
        tick(1'b0); tick(1'b0);
        chk("lock_valid_cnt", n_valid - bv, 4);
        chk("lock_mism_cnt",  n_mism - bm, 0);

        // expected high of 4 never matches
        exp_high = 16'd4;
        bv = n_valid; bm = n_mism;
        tick(1'b1); tick(1'b1); tick(1'b1);
        chk("mism_pulse",    int'(mismatch), 1);
        chk("mism_valid",    int'(meas_valid), 1);
        chk("mism_unlock",   int'(locked), 0);
        tick(1'b0); tick(1'b0);
        repeat (3) period(3, 2);
        chk("mism_valid_cnt", n_valid - bv, 4);
        chk("mism_mism_cnt",  n_mism - bm, 4);
        chk("mism_locked",    int'(locked), 0);

        exp_high = 16'd3;
        bm = n_mism;
        repeat (3) period(3, 2);
        tick(1'b1); tick(1'b1);
        chk("relock_after3", int'(locked), 0);
        tick(1'b1);
        chk("relock_after4", int'(locked), 1);
        tick(1'b0); tick(1'b0);
        chk("relock_mism_cnt", n_mism - bm, 0);

        // cin held high for TIMEOUT+10 cycles
        repeat (4) tick(1'b1);
        bv = n_valid;
        repeat (TO + 10 - 4) tick(1'b1);
        chk("stuck_set",    int'(stuck), 1);
        chk("stuck_level1", int'(stuck_level), 1);
        chk("stuck_unlock", int'(locked), 0);
        chk("stuck_no_valid", n_valid - bv, 0);
        tick(1'b0); tick(1'b0);
        chk("stuck_hold_fall", int'(stuck), 1);
        chk("stuck_level0",    int'(stuck_level), 0);
        tick(1'b1);
        chk("stuck_before_rise", int'(stuck), 1);
        tick(1'b1);
        chk("stuck_cleared", int'(stuck), 0);
        tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b1);
        chk("resume_valid_early", int'(meas_valid), 0);
        chk("resume_valid_cnt",   n_valid - bv, 0);
        tick(1'b1);
        chk("resume_valid", int'(meas_valid), 1);
        chk("resume_high",  int'(meas_high), 3);
        chk("resume_low",   int'(meas_low), 2);
        tick(1'b0); tick(1'b0);

        // asymmetric 7/1
        exp_high = 16'd7; exp_low = 16'd1;
        bv = n_valid; bm = n_mism;
        repeat (3) period(7, 1);
        chk("asym_high",      int'(meas_high), 7);
        chk("asym_low",       int'(meas_low), 1);
        chk("asym_valid_cnt", n_valid - bv, 3);
        chk("asym_mism_cnt",  n_mism - bm, 1);

        // cin toggling every cycle
        exp_high = 16'd1; exp_low = 16'd1;
        bv = n_valid; bm = n_mism;
        repeat (4) period(1, 1);
        chk("fast_high",      int'(meas_high), 1);
        chk("fast_low",       int'(meas_low), 1);
        chk("fast_valid_cnt", n_valid - bv, 3);
        chk("fast_mism_cnt",  n_mism - bm, 1);
        repeat (4) period(1, 1);
        chk("fast_locked", int'(locked), 1);

        // enable dropped mid-period
        tick(1'b1); tick(1'b1); tick(1'b1);
        enable = 1'b0;
        tick(1'b1);
        chk("dis_locked", int'(locked), 0);
        chk("dis_stuck",  int'(stuck), 0);
        chk("dis_valid",  int'(meas_valid), 0);
        bv = n_valid;
        tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
        chk("dis_no_valid", n_valid - bv, 0);
        enable = 1'b1;
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b1);
        chk("rearm_init_early", int'(init_valid), 0);
        tick(1'b1);
        chk("rearm_init_valid", int'(init_valid), 1);
        chk("rearm_initial",    int'(meas_initial), 3);
        tick(1'b1);

        // asynchronous reset pulse between edges
        reset_n = 1'b0;
        #2;
        chk("arst_initial", int'(meas_initial), 0);
        chk("arst_high",    int'(meas_high), 0);
        chk("arst_low",     int'(meas_low), 0);
        chk("arst_valid",   int'(meas_valid), 0);
        chk("arst_locked",  int'(locked), 0);
        #1;
        cin      = 1'b0;
        reset_n  = 1'b1;
        exp_high = 16'd40; exp_low = 16'd2;
        repeat (5) tick(1'b0);
        repeat (3) tick(1'b1);
        chk("arst_reinit_valid", int'(init_valid), 1);
        chk("arst_reinit",       int'(meas_initial), 6);

        // high phase of exactly TIMEOUT cycles: the fall wins over the limit
        repeat (37) tick(1'b1);
        tick(1'b0); tick(1'b0);
        chk("edge_wins_stuck", int'(stuck), 0);
        tick(1'b1); tick(1'b1);
        chk("edge_wins_early", int'(meas_valid), 0);
        tick(1'b1);
        chk("edge_wins_valid", int'(meas_valid), 1);
        chk("edge_wins_high",  int'(meas_high), 40);
        chk("edge_wins_low",   int'(meas_low), 2);
        chk("edge_wins_mism",  int'(mismatch), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
